// File: rtl/mem_stage.sv
// Memory-access pipeline stage: request/ack data-memory handshake, store lane steering and load extension.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_reg,
    input  logic [2:0]  i_opsel,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [31:0] i_res,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_rd_wen,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_vld,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_wb_data,
    output logic        o_trap
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [2:0]  opsel_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic        rd_wen_q;
    logic        mem_reg_q;
    logic [31:0] res_q;

    logic        is_req, is_byte, is_half, misaligned, start, trap_hit;
    logic [1:0]  lane;
    logic [3:0]  mask_n;
    logic [31:0] wdata_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode size and steer store lanes; H/W addresses are aligned down to their natural boundary.
    always_comb begin
        is_req  = i_vld && (i_mem_read || i_mem_write);
        is_byte = (i_opsel[1:0] == 2'b00);
        is_half = (i_opsel[1:0] == 2'b01);
        lane    = is_byte ? i_dmem_addr[1:0] : (is_half ? {i_dmem_addr[1], 1'b0} : 2'b00);
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = (is_half && i_dmem_addr[0]) || (!is_byte && !is_half && (i_dmem_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        start    = is_req && !misaligned;
        trap_hit = is_req && misaligned;
        if (is_byte) begin
            mask_n  = 4'b0001 << lane;
            wdata_n = {4{i_dmem_wdata[7:0]}};
        end else if (is_half) begin
            mask_n  = lane[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{i_dmem_wdata[15:0]}};
        end else begin
            mask_n  = 4'b1111;
            wdata_n = i_dmem_wdata;
        end
    end

    always_comb begin
        byte_sel = i_dmem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (opsel_q[1:0])
            2'b00:   load_ext = {{24{~opsel_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~opsel_q[2] & half_sel[15]}}, half_sel};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    // Upstream may only advance once the outstanding transaction is acknowledged.
    always_comb begin
        o_stall = (state == IDLE) ? start : !i_dmem_ack;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_mask  <= '0;
            o_dmem_wdata <= '0;
            o_vld        <= 1'b0;
            o_rd_wen     <= 1'b0;
            o_rd_waddr   <= '0;
            o_wb_data    <= '0;
            o_trap       <= 1'b0;
            opsel_q      <= '0;
            lane_q       <= '0;
            rd_q         <= '0;
            rd_wen_q     <= 1'b0;
            mem_reg_q    <= 1'b0;
            res_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_trap <= 1'b0;
                    if (start) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_mem_write;
                        o_dmem_addr  <= {i_dmem_addr[31:2], 2'b00};
                        o_dmem_mask  <= mask_n;
                        o_dmem_wdata <= wdata_n;
                        opsel_q      <= i_opsel;
                        lane_q       <= lane;
                        rd_q         <= i_rd_waddr;
                        rd_wen_q     <= i_rd_wen && !i_mem_write;
                        mem_reg_q    <= i_mem_reg || i_mem_read;
                        res_q        <= i_res;
                        o_vld        <= 1'b0;
                        o_rd_wen     <= 1'b0;
                        state        <= BUSY;
                    end else if (trap_hit) begin
                        o_vld      <= 1'b1;
                        o_rd_wen   <= 1'b0;
                        o_trap     <= 1'b1;
                        o_rd_waddr <= i_rd_waddr;
                        o_wb_data  <= i_dmem_addr;
                    end else begin
                        o_vld      <= i_vld;
                        o_rd_wen   <= i_rd_wen && i_vld;
                        o_rd_waddr <= i_rd_waddr;
                        o_wb_data  <= i_res;
                    end
                end
                BUSY: begin
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        o_vld      <= 1'b1;
                        o_rd_wen   <= rd_wen_q;
                        o_rd_waddr <= rd_q;
                        o_wb_data  <= mem_reg_q ? load_ext : res_q;
                        state      <= IDLE;
                    end else begin
                        o_vld    <= 1'b0;
                        o_rd_wen <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model, per-cycle compare process and directed scenarios.
// Build with MEM_MISALIGN_TRAP_EN defined to exercise the trapping variant.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        bit          vld, ld, st, mreg, rd_wen;
        logic [2:0]  opsel;
        logic [31:0] addr, wdata, res;
        logic [4:0]  rd_addr;
    } op_t;

    typedef struct {
        bit          vld, rd_wen, trap, chk_rd, chk_data;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        i_clk, i_rst, i_vld, i_mem_read, i_mem_write, i_mem_reg, i_rd_wen, i_dmem_ack;
    logic [2:0]  i_opsel;
    logic [31:0] i_dmem_addr, i_dmem_wdata, i_res, i_dmem_rdata;
    logic [4:0]  i_rd_waddr;
    logic        o_stall, o_dmem_req, o_dmem_we, o_vld, o_rd_wen, o_trap;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
    logic [3:0]  o_dmem_mask;
    logic [4:0]  o_rd_waddr;

    mem_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_mem_reg(i_mem_reg), .i_opsel(i_opsel),
        .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata), .i_res(i_res),
        .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .o_stall(o_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_vld(o_vld), .o_rd_wen(o_rd_wen),
        .o_rd_waddr(o_rd_waddr), .o_wb_data(o_wb_data), .o_trap(o_trap)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int compared = 0;
    int mismatched = 0;

    bit          checking = 0;
    bit          skip_stall = 0;
    bit          exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_mask;
    wb_t         exp_wb, pend_wb;

    int          stall_cycles = 0, req_cycles = 0, wb_count = 0;
    logic [31:0] last_addr, last_wdata, last_wb;
    logic [3:0]  last_mask;
    logic [4:0]  last_rd, prev_rd;
    bit          last_rd_wen, last_trap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] opsel);
        case (opsel)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    // Expected MEM/WB contents for an operation, given the word the memory returns.
    function automatic wb_t model(input op_t op, input logic [31:0] rdata);
        wb_t w;
        int nb, a, off;
        logic [31:0] v, m;
        w = '{default: 0};
        w.vld = op.vld;
        if (!op.vld) return w;
        if (!(op.ld || op.st)) begin
            w.rd_wen = op.rd_wen; w.rd = op.rd_addr; w.data = op.res;
            w.chk_rd = 1; w.chk_data = 1;
            return w;
        end
        nb = nbytes(op.opsel);
        a  = int'(op.addr[1:0]);
        if (TRAP && (a % nb) != 0) begin
            w.trap = 1; w.data = op.addr; w.chk_data = 1;
            return w;
        end
        if (op.st) return w;
        off = a - (a % nb);
        v = rdata >> (8 * off);
        if (nb < 4) begin
            m = (32'd1 << (8 * nb)) - 32'd1;
            v = v & m;
            if ((op.opsel == 3'd0 || op.opsel == 3'd1) && v[8*nb-1]) v = v | ~m;
        end
        w.rd_wen = op.rd_wen; w.rd = op.rd_addr; w.data = v;
        w.chk_rd = 1; w.chk_data = 1;
        return w;
    endfunction

    task automatic checkOutput();
        if (!skip_stall) chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});
        chk("dmem_req", {31'd0, o_dmem_req}, {31'd0, exp_req});
        if (exp_req) begin
            chk("dmem_we", {31'd0, o_dmem_we}, {31'd0, exp_we});
            chk("dmem_addr", o_dmem_addr, exp_addr);
            chk("dmem_mask", {28'd0, o_dmem_mask}, {28'd0, exp_mask});
            chk("dmem_wdata", o_dmem_wdata, exp_wdata);
        end
        chk("wb_vld", {31'd0, o_vld}, {31'd0, exp_wb.vld});
        if (exp_wb.vld) begin
            chk("wb_rd_wen", {31'd0, o_rd_wen}, {31'd0, exp_wb.rd_wen});
            chk("wb_trap", {31'd0, o_trap}, {31'd0, exp_wb.trap});
            if (exp_wb.chk_rd) chk("wb_rd", {27'd0, o_rd_waddr}, {27'd0, exp_wb.rd});
            if (exp_wb.chk_data) chk("wb_data", o_wb_data, exp_wb.data);
        end else begin
            chk("wb_rd_wen_bubble", {31'd0, o_rd_wen}, 32'd0);
        end
    endtask

    // Compare process plus a record of observed outputs for the directed scenarios.
    always @(negedge i_clk) begin
        if (checking) begin
            checkOutput();
            if (o_stall) stall_cycles++;
            if (o_dmem_req) begin
                req_cycles++;
                last_addr = o_dmem_addr; last_mask = o_dmem_mask; last_wdata = o_dmem_wdata;
            end
            if (o_vld) begin
                wb_count++;
                prev_rd = last_rd; last_rd = o_rd_waddr; last_rd_wen = o_rd_wen;
                last_trap = o_trap; last_wb = o_wb_data;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        exp_wb = pend_wb;
    endtask

    task automatic drive(input op_t op);
        i_vld = op.vld; i_mem_read = op.ld; i_mem_write = op.st; i_mem_reg = op.mreg;
        i_opsel = op.opsel; i_dmem_addr = op.addr; i_dmem_wdata = op.wdata;
        i_res = op.res; i_rd_waddr = op.rd_addr; i_rd_wen = op.rd_wen;
    endtask

    // Present one EX/MEM entry and hold it until accepted; delay = cycles from first request to ack.
    task automatic applyStimulus(input op_t op, input int delay, input logic [31:0] rdata);
        bit mem, trap;
        int nb, off;
        wb_t bubble;
        bubble = '{default: 0};
        drive(op);
        i_dmem_ack = 1'b0;
        mem  = op.vld && (op.ld || op.st);
        nb   = nbytes(op.opsel);
        trap = mem && TRAP && ((int'(op.addr[1:0]) % nb) != 0);
        exp_req = 0;
        if (!mem || trap) begin
            exp_stall = 0;
            pend_wb = model(op, 32'd0);
            tick();
        end else begin
            off       = int'(op.addr[1:0]) - (int'(op.addr[1:0]) % nb);
            exp_we    = op.st;
            exp_addr  = op.addr & ~32'h3;
            exp_mask  = 4'(((1 << nb) - 1) << off);
            for (int l = 0; l < 4; l++) exp_wdata[8*l +: 8] = op.wdata[8*(l % nb) +: 8];
            exp_stall = 1;
            pend_wb = bubble;
            tick();
            for (int k = 1; k <= delay; k++) begin
                exp_req = 1;
                i_dmem_ack = (k == delay);
                i_dmem_rdata = (k == delay) ? rdata : $urandom;
                exp_stall = (k != delay);
                pend_wb = (k == delay) ? model(op, rdata) : bubble;
                tick();
            end
            i_dmem_ack = 1'b0;
            exp_req = 0;
        end
    endtask

    function automatic op_t mk(input bit ld, input bit st, input logic [2:0] opsel,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] res, input logic [4:0] rd);
        op_t o;
        o.vld = 1; o.ld = ld; o.st = st; o.mreg = ld; o.rd_wen = !st;
        o.opsel = opsel; o.addr = addr; o.wdata = wdata; o.res = res; o.rd_addr = rd;
        return o;
    endfunction

    task automatic idle();
        op_t o;
        o = mk(0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        o.vld = 0;
        applyStimulus(o, 1, 32'd0);
    endtask

    initial begin
        op_t o;
        int  n0, r0;
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        op_t o;
        int  n0, r0;
        wb_t bw;
        bw = '{default: 0};
        exp_wb = bw; pend_wb = bw; exp_stall = 0; exp_req = 0;
        exp_we = 0; exp_addr = 0; exp_mask = 0; exp_wdata = 0;
        last_rd = 0; prev_rd = 0;
        i_rst = 1; i_dmem_ack = 0; i_dmem_rdata = 0;
        o = mk(0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        o.vld = 0;
        drive(o);
        tick(); tick();
        chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
        chk("rst_we", {31'd0, o_dmem_we}, 32'd0);
        chk("rst_mask", {28'd0, o_dmem_mask}, 32'd0);
        chk("rst_vld", {31'd0, o_vld}, 32'd0);
        chk("rst_rd_wen", {31'd0, o_rd_wen}, 32'd0);
        chk("rst_trap", {31'd0, o_trap}, 32'd0);
        chk("rst_rd", {27'd0, o_rd_waddr}, 32'd0);
        chk("rst_wb", o_wb_data, 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_wdata", o_dmem_wdata, 32'd0);
        i_rst = 0;
        checking = 1;
        idle();

        // Pin the model on hand-computed loads.
        bw = model(mk(1, 0, 3'd0, 32'h103, 32'd0, 32'd0, 5'd1), 32'h80FF_0000);
        chk("model_lb", bw.data, 32'hFFFF_FF80);
        bw = model(mk(1, 0, 3'd5, 32'h102, 32'd0, 32'd0, 5'd1), 32'h8001_7FFF);
        chk("model_lhu", bw.data, 32'h0000_8001);

        // ALU op passes straight through without stalling.
        stall_cycles = 0; n0 = wb_count;
        applyStimulus(mk(0, 0, 3'd0, 32'd0, 32'd0, 32'h1234, 5'd5), 1, 32'd0);
        idle();
        chk("alu_stall_cycles", stall_cycles, 32'd0);
        chk("alu_wb_count", wb_count - n0, 32'd1);
        chk("alu_wb", last_wb, 32'h1234);
        chk("alu_rd", {27'd0, last_rd}, 32'd5);

        // Byte loads, signed and unsigned, from the top lane.
        applyStimulus(mk(1, 0, 3'd0, 32'h103, 32'd0, 32'd0, 5'd3), 1, 32'h80FF_0000);
        idle();
        chk("lb_addr", last_addr, 32'h100);
        chk("lb_mask", {28'd0, last_mask}, 32'h8);
        chk("lb_wb", last_wb, 32'hFFFF_FF80);
        applyStimulus(mk(1, 0, 3'd4, 32'h103, 32'd0, 32'd0, 5'd3), 1, 32'h80FF_0000);
        idle();
        chk("lbu_wb", last_wb, 32'h0000_0080);

        // Halfword store with a slow acknowledge.
        stall_cycles = 0;
        applyStimulus(mk(0, 1, 3'd1, 32'h202, 32'h0000_ABCD, 32'd0, 5'd4), 4, 32'd0);
        idle();
        chk("sh_mask", {28'd0, last_mask}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_stall_cycles", stall_cycles, 32'd4);
        chk("sh_rd_wen", {31'd0, last_rd_wen}, 32'd0);

        // Misaligned word load.
        stall_cycles = 0; r0 = req_cycles;
        applyStimulus(mk(1, 0, 3'd2, 32'h301, 32'd0, 32'd0, 5'd6), 1, 32'h1122_3344);
        idle();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lw_mis_req_cycles", req_cycles - r0, 32'd0);
        chk("lw_mis_stall", stall_cycles, 32'd0);
        chk("lw_mis_trap", {31'd0, last_trap}, 32'd1);
        chk("lw_mis_wb", last_wb, 32'h301);
`else
        chk("lw_mis_addr", last_addr, 32'h300);
        chk("lw_mis_mask", {28'd0, last_mask}, 32'hF);
        chk("lw_mis_trap", {31'd0, last_trap}, 32'd0);
`endif

        // Back-to-back word loads with immediate acks.
        n0 = wb_count;
        applyStimulus(mk(1, 0, 3'd2, 32'h400, 32'd0, 32'd0, 5'd7), 1, 32'hAAAA_0001);
        applyStimulus(mk(1, 0, 3'd2, 32'h404, 32'd0, 32'd0, 5'd9), 1, 32'hBBBB_0002);
        idle();
        chk("b2b_wb_count", wb_count - n0, 32'd2);
        chk("b2b_rd_first", {27'd0, prev_rd}, 32'd7);
        chk("b2b_rd_second", {27'd0, last_rd}, 32'd9);
        chk("b2b_wb_second", last_wb, 32'hBBBB_0002);

        // Reset while a load is outstanding; the ack that follows must be ignored.
        n0 = wb_count;
        o = mk(1, 0, 3'd2, 32'h500, 32'd0, 32'd0, 5'd8);
        drive(o);
        exp_we = 0; exp_addr = 32'h500; exp_mask = 4'hF; exp_wdata = 32'd0;
        exp_stall = 1; exp_req = 0; pend_wb = '{default: 0};
        tick();
        i_rst = 1; skip_stall = 1; exp_req = 1;
        tick();
        i_rst = 0; skip_stall = 0; exp_req = 0; exp_stall = 0;
        o.vld = 0;
        drive(o);
        i_dmem_ack = 1; i_dmem_rdata = 32'hDEAD_BEEF;
        tick();
        i_dmem_ack = 0;
        idle();
        chk("rst_busy_wb_count", wb_count - n0, 32'd0);

        // Randomized mix of loads, stores, ALU ops and bubbles.
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            o = mk(kind < 4, (kind >= 4) && (kind < 7), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
            o.vld = ($urandom_range(0, 7) != 0);
            o.rd_wen = $urandom_range(0, 1);
            if (o.st) o.mreg = 0;
            applyStimulus(o, $urandom_range(1, 4), $urandom);
        end
        idle();
        idle();
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
